codec_vol_ctrl: RTL and testbench
=================================

Name: codec_vol_ctrl

Overview:
Volume controller for the WM8731 headphone output on the 50 MHz system clock. It synchronises and debounces the vol_add/vol_sub buttons and generates single steps plus auto-repeat. The volume is saturated to a legal range. Each change is scheduled as one 16-bit register write to the I2C config master over a req/ack handshake, with coalescing, ack timeout and retry.

Parameters:
DEB_CYC, 1000000, stable cycles for a debounced level change (20 ms).
REP_CYC, 10000000, hold cycles before the first auto-repeat step, and between later steps (200 ms).
ACK_TO_CYC, 5000000, maximum cycles from i2c_req rise to i2c_ack before timeout.
VOL_RESET, 7'h78, volume after reset.
VOL_MAX, 7'h7F, upper saturation limit (+6 dB).
VOL_MIN, 7'h30, lower saturation limit (-73 dB; 7'h2F and below mute).
ZC_EN, 1'b0, value of the zero-cross enable bit in the written word.

Ports:
sys_clk  in  1  system clock, 50 MHz.
sys_rst  in  1  synchronous, active-high reset.
vol_add  in  1  raw button, active-high, asynchronous.
vol_sub  in  1  raw button, active-high, asynchronous.
cfg_done  in  1  initial codec configuration complete (level).
i2c_ack  in  1  one-cycle pulse: requested write finished.
i2c_req  out  1  write request; held high until ack or timeout.
i2c_word  out  16  {7'h02, 1'b1 (LRHPBOTH), ZC_EN, vol[6:0]}.
spk_vol  out  7  current volume.
err  out  1  sticky flag: at least one ack timeout occurred.

Behaviour:
- Reset (sys_rst high at a sys_clk edge; takes effect mid-operation too):
  - spk_vol=VOL_RESET, i2c_req=0, i2c_word=16'h0000, err=0.
  - dirty=0, debounce and repeat counters 0, debounced levels 0, FSM=S_INIT.
  - A pending request is dropped without waiting for ack.
- Input conditioning: 2-FF synchroniser per button.
  - Debounced level changes once the synchronised input differs from it for DEB_CYC consecutive cycles.
  - Any mismatch-free cycle clears that button's counter.
- Step events, one-cycle strobes:
  - On a debounced 0->1 edge of exactly one button.
  - While that button stays held alone: one further strobe after each REP_CYC cycles.
  - Both debounced high: no strobes, repeat counters held at 0. Release of one button resumes repeat from 0 for the other.
- Volume update, registered in the cycle after the strobe:
  - add: spk_vol = (spk_vol==VOL_MAX) ? VOL_MAX : spk_vol+1.
  - sub: spk_vol = (spk_vol==VOL_MIN) ? VOL_MIN : spk_vol-1.
  - dirty is set only if the value changed; saturated steps generate no write.
- Write FSM:
  - S_INIT: wait for cfg_done=1 -> S_IDLE. Steps are still accepted here; resulting dirty is serviced after cfg_done. Reset volume is assumed written by the initial config.
  - S_IDLE: if dirty, then i2c_word <= format(spk_vol), i2c_req <= 1, dirty cleared, timeout counter 0 -> S_REQ. Latency: strobe at cycle N, spk_vol updated N+1, i2c_req high N+2.
  - S_REQ: i2c_word stable. On i2c_ack: i2c_req <= 0 -> S_IDLE. When the counter reaches ACK_TO_CYC: i2c_req <= 0, err <= 1, dirty <= 1 (retry) -> S_IDLE.
  - Volume change during S_REQ sets dirty. Only the latest spk_vol is written next (coalescing); a minimum of one idle cycle separates requests.
  - An ack coinciding with the timeout cycle counts as success (no err).
  - i2c_ack outside S_REQ is ignored.
  - cfg_done falling after S_INIT is ignored.
- Width rules: counters are sized ceil(log2(max param+1)); no arithmetic wrap is possible because of the saturation.

Test Plan:
Bench parameters: DEB_CYC=4, REP_CYC=16, ACK_TO_CYC=32, acking master model.
1. Reset, cfg_done=1, single 10-cycle vol_sub press with 2-cycle bounce at both edges -> exactly one step; spk_vol 7'h78->7'h77; one request with i2c_word=16'h0577; i2c_req drops the cycle after ack.
2. Hold vol_add from spk_vol=7'h78 for 100 cycles -> spk_vol saturates at 7'h7F after 7 steps; further strobes produce no request; exactly 7 writes (fewer if coalesced), last word 16'h057F.
3. Three vol_sub steps while the master withholds ack for 20 cycles -> first word 16'h0577; after ack exactly one more request with 16'h0575 (coalesced).
4. Master never acks -> i2c_req falls 32 cycles after rise; err=1; retry request with the same word; a later ack clears i2c_req, err stays 1.
5. Both buttons held together -> no strobes, no change; release vol_sub -> vol_add auto-repeat restarts with the first step 16 cycles later.
6. Steps before cfg_done, and sys_rst asserted during S_REQ -> no request until cfg_done; reset forces i2c_req=0, spk_vol=7'h78, err=0 on the next edge.

Source files
------------

// File: rtl/codec_vol_ctrl.sv
// rtl/codec_vol_ctrl.sv - WM8731 headphone volume control: button debounce, auto-repeat, saturated volume, I2C write scheduling
module codec_vol_ctrl #(
    parameter int unsigned DEB_CYC    = 1000000,
    parameter int unsigned REP_CYC    = 10000000,
    parameter int unsigned ACK_TO_CYC = 5000000,
    parameter logic [6:0]  VOL_RESET  = 7'h78,
    parameter logic [6:0]  VOL_MAX    = 7'h7F,
    parameter logic [6:0]  VOL_MIN    = 7'h30,
    parameter logic        ZC_EN      = 1'b0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        vol_add,
    input  logic        vol_sub,
    input  logic        cfg_done,
    input  logic        i2c_ack,
    output logic        i2c_req,
    output logic [15:0] i2c_word,
    output logic [6:0]  spk_vol,
    output logic        err
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int RW = $clog2(REP_CYC + 1);
    localparam int TW = $clog2(ACK_TO_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [RW-1:0] REP_HIT  = RW'(REP_CYC);
    localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TO_CYC - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_REQ} state_t;

    // Button index 0 is vol_add, index 1 is vol_sub.
    logic [1:0]    raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    deb_q, deb_d, deb_prev_q;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];
    logic [RW-1:0] rep_cnt_q [2];
    logic [RW-1:0] rep_cnt_d [2];
    logic [1:0]    alone, stb;

    state_t        state_q, state_d;
    logic [6:0]    vol_q, vol_d;
    logic          vol_chg;
    logic          dirty_q, dirty_d;
    logic          req_q, req_d;
    logic          err_q, err_d;
    logic [15:0]   word_q, word_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    assign raw   = {vol_sub, vol_add};
    assign alone = {deb_q[1] & ~deb_q[0], deb_q[0] & ~deb_q[1]};

    always_comb begin
        deb_d = deb_q;
        stb   = '0;
        for (int i = 0; i < 2; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
                else deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
            // Repeat counter restarts at 1 on each strobe so every period is REP_CYC cycles.
            stb[i] = alone[i] & ((deb_q[i] & ~deb_prev_q[i]) | (rep_cnt_q[i] == REP_HIT));
            if (!alone[i])  rep_cnt_d[i] = '0;
            else if (stb[i]) rep_cnt_d[i] = RW'(1);
            else            rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
    end

    always_comb begin
        vol_d   = vol_q;
        vol_chg = 1'b0;
        if (stb[0] && vol_q != VOL_MAX) begin
            vol_d   = vol_q + 7'd1;
            vol_chg = 1'b1;
        end else if (stb[1] && vol_q != VOL_MIN) begin
            vol_d   = vol_q - 7'd1;
            vol_chg = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        word_d   = word_q;
        err_d    = err_q;
        dirty_d  = dirty_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            S_INIT: if (cfg_done) state_d = S_IDLE;
            S_IDLE: begin
                if (dirty_q) begin
                    word_d   = {7'h02, 1'b1, ZC_EN, vol_q};
                    req_d    = 1'b1;
                    dirty_d  = 1'b0;
                    to_cnt_d = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                // Ack wins over a timeout in the same cycle.
                if (i2c_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    dirty_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
        if (vol_chg) dirty_d = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
                rep_cnt_q[i] <= '0;
            end
            state_q    <= S_INIT;
            vol_q      <= VOL_RESET;
            dirty_q    <= 1'b0;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
            word_q     <= 16'h0000;
            to_cnt_q   <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
            state_q    <= state_d;
            vol_q      <= vol_d;
            dirty_q    <= dirty_d;
            req_q      <= req_d;
            err_q      <= err_d;
            word_q     <= word_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign i2c_req  = req_q;
    assign i2c_word = word_q;
    assign spk_vol  = vol_q;
    assign err      = err_q;

endmodule

// File: tb/tb_codec_vol_ctrl.sv
// tb/tb_codec_vol_ctrl.sv - self-checking bench for codec_vol_ctrl with reference model and acking I2C master
module tb_codec_vol_ctrl;

    localparam int DEB = 4;
    localparam int REP = 16;
    localparam int ATO = 32;

    logic        sys_clk  = 1'b0;
    logic        sys_rst  = 1'b1;
    logic        vol_add  = 1'b0;
    logic        vol_sub  = 1'b0;
    logic        cfg_done = 1'b0;
    logic        i2c_ack  = 1'b0;
    logic        i2c_req;
    logic [15:0] i2c_word;
    logic [6:0]  spk_vol;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    codec_vol_ctrl #(
        .DEB_CYC(DEB),
        .REP_CYC(REP),
        .ACK_TO_CYC(ATO)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .vol_add (vol_add),
        .vol_sub (vol_sub),
        .cfg_done(cfg_done),
        .i2c_ack (i2c_ack),
        .i2c_req (i2c_req),
        .i2c_word(i2c_word),
        .spk_vol (spk_vol),
        .err     (err)
    );

    always #10 sys_clk = ~sys_clk;

    // I2C master: acks ack_delay cycles after it first sees a request.
    bit ack_en    = 1'b1;
    int ack_delay = 3;
    int seen      = 0;
    bit acked     = 1'b0;
    always @(negedge sys_clk) begin
        i2c_ack = 1'b0;
        if (i2c_req === 1'b1 && !acked) begin
            if (ack_en && seen >= ack_delay) begin
                i2c_ack = 1'b1;
                acked   = 1'b1;
            end else begin
                seen++;
            end
        end
        if (i2c_req !== 1'b1) begin
            seen  = 0;
            acked = 1'b0;
        end
    end

    logic [15:0] wq[$];
    bit          prev_req = 1'b0;
    always @(negedge sys_clk) begin
        if (i2c_req === 1'b1 && !prev_req) wq.push_back(i2c_word);
        prev_req = (i2c_req === 1'b1);
    end

    // Reference model: debounce as "last DEB synced samples all disagree",
    // repeat as a modulo of edges since the button became the only one held.
    bit          m_valid = 1'b0;
    logic [6:0]  m_vol;
    logic        m_req, m_err, m_dirty;
    logic [15:0] m_word;
    int          m_phase, m_age, edge_n;
    bit          dq_a[$], dq_s[$], win_a[$], win_s[$];
    bit          m_deb_a, m_deb_s, m_stb_add, m_stb_sub, alone_rose;
    int          alone_btn, alone_start;

    function automatic bit all_ne(bit q[$], bit v);
        if (q.size() != DEB) return 1'b0;
        foreach (q[i]) if (q[i] == v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge sys_clk) begin : model
        bit sa, ss, oa, os, chg;
        logic [6:0] nv;
        int nb;
        if (sys_rst === 1'b1) begin
            m_valid = 1'b1;
            m_vol = 7'h78; m_req = 0; m_err = 0; m_dirty = 0; m_word = 16'h0000;
            m_phase = 0; m_age = 0; edge_n = 0;
            dq_a = '{0, 0}; dq_s = '{0, 0}; win_a.delete(); win_s.delete();
            m_deb_a = 0; m_deb_s = 0; m_stb_add = 0; m_stb_sub = 0;
            alone_btn = 0; alone_start = 0; alone_rose = 0;
        end else if (m_valid) begin
            edge_n++;
            nv = m_vol; chg = 0;
            if (m_stb_add && m_vol != 7'h7F) begin nv = m_vol + 7'd1; chg = 1; end
            if (m_stb_sub && m_vol != 7'h30) begin nv = m_vol - 7'd1; chg = 1; end
            if (m_phase == 0) begin
                if (cfg_done) m_phase = 1;
            end else if (m_phase == 1) begin
                if (m_dirty) begin
                    m_word = {7'h02, 1'b1, 1'b0, m_vol};
                    m_req = 1; m_dirty = 0; m_age = 0; m_phase = 2;
                end
            end else begin
                if (i2c_ack) begin m_req = 0; m_phase = 1; end
                else if (m_age == ATO - 1) begin m_req = 0; m_err = 1; m_dirty = 1; m_phase = 1; end
                else m_age++;
            end
            if (chg) begin m_vol = nv; m_dirty = 1; end
            sa = dq_a.pop_front(); dq_a.push_back(vol_add);
            ss = dq_s.pop_front(); dq_s.push_back(vol_sub);
            win_a.push_back(sa); if (win_a.size() > DEB) void'(win_a.pop_front());
            win_s.push_back(ss); if (win_s.size() > DEB) void'(win_s.pop_front());
            oa = m_deb_a; os = m_deb_s;
            if (all_ne(win_a, m_deb_a)) begin m_deb_a = !m_deb_a; win_a.delete(); end
            if (all_ne(win_s, m_deb_s)) begin m_deb_s = !m_deb_s; win_s.delete(); end
            nb = (m_deb_a && !m_deb_s) ? 1 : (m_deb_s && !m_deb_a) ? 2 : 0;
            if (nb != alone_btn) begin
                alone_btn   = nb;
                alone_start = edge_n;
                alone_rose  = (nb == 1) ? (m_deb_a && !oa) : (nb == 2) ? (m_deb_s && !os) : 1'b0;
            end
            m_stb_add = (alone_btn == 1) && ((alone_rose && edge_n == alone_start) ||
                        (edge_n > alone_start && (edge_n - alone_start) % REP == 0));
            m_stb_sub = (alone_btn == 2) && ((alone_rose && edge_n == alone_start) ||
                        (edge_n > alone_start && (edge_n - alone_start) % REP == 0));
        end
    end

    always @(negedge sys_clk) begin
        if (m_valid) begin
            n_cmp++;
            if (spk_vol !== m_vol || i2c_req !== m_req || i2c_word !== m_word || err !== m_err) begin
                n_fail++;
                $display("FAIL model t=%0t got vol=%h req=%b word=%h err=%b need vol=%h req=%b word=%h err=%b",
                         $time, spk_vol, i2c_req, i2c_word, err, m_vol, m_req, m_word, m_err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h need %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        cyc(2);
        sys_rst = 1'b0;
        wq.delete();
    endtask

    task automatic wait_req(input logic lvl, input int lim, output int k);
        k = 0;
        while (i2c_req !== lvl && k < lim) begin cyc(1); k++; end
    endtask

    initial begin
        int k;
        cyc(3);
        chk("rst_vol", spk_vol, 7'h78);
        chk("rst_req", i2c_req, 1'b0);
        chk("rst_word", i2c_word, 16'h0000);
        chk("rst_err", err, 1'b0);
        sys_rst = 1'b0;

        // 1: bouncy single press
        cfg_done = 1'b1;
        cyc(2);
        vol_sub = 1; cyc(1); vol_sub = 0; cyc(1); vol_sub = 1; cyc(10);
        vol_sub = 0; cyc(1); vol_sub = 1; cyc(1); vol_sub = 0;
        cyc(40);
        chk("t1_vol", spk_vol, 7'h77);
        chk("t1_nreq", wq.size(), 1);
        chk("t1_word", (wq.size() > 0) ? wq[0] : 16'hFFFF, 16'h0577);

        // 2: hold add into saturation
        do_reset();
        vol_add = 1; cyc(100); vol_add = 0;
        cyc(40);
        chk("t2_vol", spk_vol, 7'h7F);
        chk("t2_nreq", wq.size(), 7);
        chk("t2_last", (wq.size() > 0) ? wq[wq.size()-1] : 16'hFFFF, 16'h057F);

        // 3: coalescing while ack is withheld
        do_reset();
        ack_delay = 20;
        repeat (3) begin vol_sub = 1; cyc(5); vol_sub = 0; cyc(4); end
        cyc(80);
        chk("t3_nreq", wq.size(), 2);
        chk("t3_w0", (wq.size() > 0) ? wq[0] : 16'hFFFF, 16'h0577);
        chk("t3_w1", (wq.size() > 1) ? wq[1] : 16'hFFFF, 16'h0575);
        chk("t3_vol", spk_vol, 7'h75);

        // 4: timeout and retry
        do_reset();
        ack_delay = 2; ack_en = 0;
        vol_sub = 1; cyc(5); vol_sub = 0;
        wait_req(1'b1, 50, k);
        chk("t4_rise", i2c_req, 1'b1);
        wait_req(1'b0, 100, k);
        chk("t4_hi_len", k, ATO);
        chk("t4_err", err, 1'b1);
        wait_req(1'b1, 20, k);
        chk("t4_retry", i2c_req, 1'b1);
        chk("t4_retry_word", i2c_word, 16'h0577);
        ack_en = 1;
        wait_req(1'b0, 20, k);
        chk("t4_ack_req", i2c_req, 1'b0);
        chk("t4_err_sticky", err, 1'b1);
        chk("t4_nreq", wq.size(), 2);

        // 5: both held, then release sub
        do_reset();
        ack_delay = 3;
        vol_add = 1; vol_sub = 1; cyc(60);
        chk("t5_both_vol", spk_vol, 7'h78);
        chk("t5_both_nreq", wq.size(), 0);
        vol_sub = 0;
        k = 0;
        while (spk_vol === 7'h78 && k < 60) begin cyc(1); k++; end
        chk("t5_latency", k, 2 + DEB + REP + 1);
        chk("t5_vol", spk_vol, 7'h79);
        vol_add = 0; cyc(30);

        // 6: steps before cfg_done, reset during a request
        cfg_done = 0; ack_en = 0;
        do_reset();
        vol_sub = 1; cyc(5); vol_sub = 0; cyc(30);
        chk("t6_noreq", wq.size(), 0);
        chk("t6_vol", spk_vol, 7'h77);
        cfg_done = 1;
        wait_req(1'b1, 20, k);
        chk("t6_word", i2c_word, 16'h0577);
        cyc(40);
        chk("t6_err", err, 1'b1);
        chk("t6_inreq", i2c_req, 1'b1);
        sys_rst = 1; cyc(1);
        chk("t6_rst_req", i2c_req, 1'b0);
        chk("t6_rst_vol", spk_vol, 7'h78);
        chk("t6_rst_err", err, 1'b0);
        sys_rst = 0; ack_en = 1;
        cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
